// File: rtl/trivium_pkg.sv
// trivium_pkg: shared Trivium constants, tap positions (1-based, as in the cipher definition) and FSM states.
package trivium_pkg;
   localparam int STATE_W       = 288;
   localparam int KEY_W         = 80;
   localparam int IV_W          = 80;
   localparam int WARMUP_ROUNDS = 1152;
   localparam int A_T = 66,  A_L = 93,  A_M0 = 91,  A_M1 = 92,  A_X = 171;
   localparam int B_T = 162, B_L = 177, B_M0 = 175, B_M1 = 176, B_X = 264;
   localparam int C_T = 243, C_L = 288, C_M0 = 286, C_M1 = 287, C_X = 69;
   typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;
endpackage

// File: rtl/trivium_round.sv
// trivium_round: one combinational Trivium round; bit i of the state vector holds s(i+1).
module trivium_round
   import trivium_pkg::*;
(
   input  logic [STATE_W-1:0] s,
   output logic [STATE_W-1:0] s_nxt,
   output logic               z
);
   logic ta, tb, tc;
   assign ta = s[A_T-1] ^ s[A_L-1] ^ (s[A_M0-1] & s[A_M1-1]) ^ s[A_X-1];
   assign tb = s[B_T-1] ^ s[B_L-1] ^ (s[B_M0-1] & s[B_M1-1]) ^ s[B_X-1];
   assign tc = s[C_T-1] ^ s[C_L-1] ^ (s[C_M0-1] & s[C_M1-1]) ^ s[C_X-1];
   assign z  = s[A_T-1] ^ s[A_L-1] ^ s[B_T-1] ^ s[B_L-1] ^ s[C_T-1] ^ s[C_L-1];
   // each of the three shift registers takes the feedback computed from its predecessor
   assign s_nxt = {s[C_L-2:B_L], tb, s[B_L-2:A_L], ta, s[A_L-2:0], tc};
endmodule

// File: rtl/trivium_wide.sv
// trivium_wide: W-rounds-per-clock Trivium stream cipher with parallel key/IV load
// and a valid/ready word stream (dat_o = dat_i ^ keystream).
module trivium_wide #(
   parameter int W     = 32,
   parameter int KEY_W = 80,
   parameter int IV_W  = 80
) (
   input  logic             clk_i,
   input  logic             n_rst_i,
   input  logic             init_i,
   input  logic             end_i,
   input  logic [KEY_W-1:0] key_i,
   input  logic [IV_W-1:0]  iv_i,
   output logic             busy_init_o,
   input  logic [W-1:0]     dat_i,
   input  logic             dat_vld_i,
   output logic             dat_rdy_o,
   output logic [W-1:0]     dat_o,
   output logic             dat_vld_o,
   input  logic             dat_rdy_i
);
   import trivium_pkg::*;
   localparam int CNT_N = WARMUP_ROUNDS / W;
   localparam int CNT_W = $clog2(CNT_N);
   state_t state_q, state_d;
   logic [STATE_W-1:0] st, load_s;
   logic [STATE_W-1:0] chain [0:W];
   logic [W-1:0] ks;
   logic [CNT_W-1:0] cnt;
   logic accept;
   assign load_s = {3'b111, 112'b0, iv_i, 13'b0, key_i};
   assign chain[0] = st;
   for (genvar g = 0; g < W; g++) begin : g_rnd
      trivium_round u_rnd (.s(chain[g]), .s_nxt(chain[g+1]), .z(ks[g]));
   end
   always_comb begin
      state_d     = init_i ? WARMUP : end_i ? IDLE : (state_q == WARMUP && cnt == '0) ? RUN : state_q;
      busy_init_o = state_q == WARMUP;
      // init_i/end_i override the stream, so never advertise ready in that cycle
      dat_rdy_o   = state_q == RUN && !init_i && !end_i && (!dat_vld_o || dat_rdy_i);
      accept      = dat_vld_i && dat_rdy_o;
   end
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         st        <= '0;
         cnt       <= '0;
         dat_o     <= '0;
         dat_vld_o <= 1'b0;
      end else if (init_i) begin
         st        <= load_s;
         cnt       <= CNT_W'(CNT_N - 1);
         dat_vld_o <= 1'b0;
      end else if (end_i) begin
         st        <= '0;
         dat_vld_o <= 1'b0;
      end else if (state_q == WARMUP) begin
         st <= chain[W];
         if (cnt != '0) cnt <= cnt - CNT_W'(1);
      end else if (state_q == RUN) begin
         if (accept) begin
            st        <= chain[W];
            dat_o     <= dat_i ^ ks;
            dat_vld_o <= 1'b1;
         end else if (dat_rdy_i) dat_vld_o <= 1'b0;
      end
   end
endmodule

// File: tb/tb_trivium_wide.sv
// tb_trivium_wide: directed checks of trivium_wide at W=32, W=1 and W=8 against a bit-serial Trivium model.
module tb_trivium_wide;
   logic clk = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;
   int n_chk = 0;
   int n_fail = 0;
   localparam logic [79:0] K1 = 80'h0123456789ABCDEF0123;
   localparam logic [79:0] V1 = 80'hFEDCBA98765432100000;
   localparam logic [79:0] K2 = 80'h00112233445566778899;
   localparam logic [79:0] V2 = 80'h0F1E2D3C4B5A69788796;
   localparam logic [31:0] PT = 32'hA5A5A5A5;

   logic a_init = 0, a_end = 0, a_busy, a_vi = 0, a_ro, a_vo, a_ri = 0;
   logic [79:0] a_key = '0, a_iv = '0;
   logic [31:0] a_di = '0, a_do;
   logic b_init = 0, b_end = 0, b_busy, b_vi = 0, b_ro, b_vo, b_ri = 0;
   logic [79:0] b_key = '0, b_iv = '0;
   logic [0:0] b_di = '0, b_do;
   logic c_init = 0, c_end = 0, c_busy, c_vi = 0, c_ro, c_vo, c_ri = 0;
   logic [79:0] c_key = '0, c_iv = '0;
   logic [7:0] c_di = '0, c_do;

   trivium_wide #(.W(32)) dut32 (.clk_i(clk), .n_rst_i(n_rst), .init_i(a_init), .end_i(a_end),
      .key_i(a_key), .iv_i(a_iv), .busy_init_o(a_busy), .dat_i(a_di), .dat_vld_i(a_vi),
      .dat_rdy_o(a_ro), .dat_o(a_do), .dat_vld_o(a_vo), .dat_rdy_i(a_ri));
   trivium_wide #(.W(1)) dut1 (.clk_i(clk), .n_rst_i(n_rst), .init_i(b_init), .end_i(b_end),
      .key_i(b_key), .iv_i(b_iv), .busy_init_o(b_busy), .dat_i(b_di), .dat_vld_i(b_vi),
      .dat_rdy_o(b_ro), .dat_o(b_do), .dat_vld_o(b_vo), .dat_rdy_i(b_ri));
   trivium_wide #(.W(8)) dut8 (.clk_i(clk), .n_rst_i(n_rst), .init_i(c_init), .end_i(c_end),
      .key_i(c_key), .iv_i(c_iv), .busy_init_o(c_busy), .dat_i(c_di), .dat_vld_i(c_vi),
      .dat_rdy_o(c_ro), .dat_o(c_do), .dat_vld_o(c_vo), .dat_rdy_i(c_ri));

   // bit-serial reference: m_s[i-1] holds s(i)
   logic [287:0] m_s;
   logic [31:0] ks_k1 [64];

   task automatic m_round(output logic z);
      logic t1, t2, t3;
      t1 = m_s[65] ^ m_s[92];
      t2 = m_s[161] ^ m_s[176];
      t3 = m_s[242] ^ m_s[287];
      z = t1 ^ t2 ^ t3;
      t1 = t1 ^ (m_s[90] & m_s[91]) ^ m_s[170];
      t2 = t2 ^ (m_s[174] & m_s[175]) ^ m_s[263];
      t3 = t3 ^ (m_s[285] & m_s[286]) ^ m_s[68];
      m_s = {m_s[286:177], t2, m_s[175:93], t1, m_s[91:0], t3};
   endtask

   task automatic m_init(input logic [79:0] k, input logic [79:0] v);
      logic z;
      m_s = '0;
      for (int i = 0; i < 80; i++) begin
         m_s[i] = k[i];
         m_s[93+i] = v[i];
      end
      m_s[287:285] = 3'b111;
      repeat (1152) m_round(z);
   endtask

   task automatic m_word(input int w, output logic [63:0] r);
      logic z;
      r = '0;
      for (int k = 0; k < w; k++) begin
         m_round(z);
         r[k] = z;
      end
   endtask

   task automatic a_start(input logic [79:0] k, input logic [79:0] v, output int cyc);
      @(negedge clk);
      a_key = k; a_iv = v; a_init = 1'b1;
      @(negedge clk);
      a_init = 1'b0;
      cyc = 0;
      while (a_busy && cyc < 3000) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic b_start(input logic [79:0] k, input logic [79:0] v, output int cyc);
      @(negedge clk);
      b_key = k; b_iv = v; b_init = 1'b1;
      @(negedge clk);
      b_init = 1'b0;
      cyc = 0;
      while (b_busy && cyc < 3000) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic c_start(input logic [79:0] k, input logic [79:0] v, output int cyc);
      @(negedge clk);
      c_key = k; c_iv = v; c_init = 1'b1;
      @(negedge clk);
      c_init = 1'b0;
      cyc = 0;
      while (c_busy && cyc < 3000) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_chk++;
      if ({a_busy, a_ro, a_vo, a_do} !== 35'd0) begin
         n_fail++;
         $display("FAIL reset_w32: busy/rdy/vld/dat = %b/%b/%b/%h, expected all 0", a_busy, a_ro, a_vo, a_do);
      end
      n_chk++;
      if ({b_busy, b_ro, b_vo, b_do, c_busy, c_ro, c_vo, c_do} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_w1_w8: outputs %b %b %b %b / %b %b %b %h, expected all 0",
                  b_busy, b_ro, b_vo, b_do, c_busy, c_ro, c_vo, c_do);
      end
      n_rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_warmup();
      int cyc;
      logic [63:0] z;
      @(negedge clk);
      a_key = '0; a_iv = '0; a_init = 1'b1;
      @(negedge clk);
      a_init = 1'b0;
      cyc = 0;
      while (a_busy && cyc < 100) begin
         n_chk++;
         if (a_ro !== 1'b0) begin
            n_fail++;
            $display("FAIL warmup_rdy: dat_rdy_o=%b in warm-up cycle %0d, expected 0", a_ro, cyc);
         end
         cyc++;
         @(negedge clk);
      end
      n_chk++;
      if (cyc != 36) begin
         n_fail++;
         $display("FAIL warmup_len: busy for %0d cycles, expected 36", cyc);
      end
      n_chk++;
      if (a_ro !== 1'b1) begin
         n_fail++;
         $display("FAIL run_rdy: dat_rdy_o=%b in first RUN cycle, expected 1", a_ro);
      end
      m_init('0, '0);
      m_word(32, z);
      a_ri = 1'b1; a_vi = 1'b1; a_di = '0;
      @(negedge clk);
      a_vi = 1'b0;
      n_chk++;
      if ({a_vo, a_do} !== {1'b1, z[31:0]}) begin
         n_fail++;
         $display("FAIL zero_key_word: vld/dat=%b/%h, expected 1/%h", a_vo, a_do, z[31:0]);
      end
   endtask

   task automatic test_equiv();
      int cyc;
      logic [63:0] z;
      logic [31:0] r;
      m_init(K1, V1);
      for (int i = 0; i < 64; i++) begin
         m_word(32, z);
         ks_k1[i] = z[31:0];
      end
      a_start(K1, V1, cyc);
      n_chk++;
      if (cyc != 36) begin
         n_fail++;
         $display("FAIL equiv_w32_warmup: %0d cycles, expected 36", cyc);
      end
      a_ri = 1'b1;
      for (int i = 0; i < 64; i++) begin
         a_vi = 1'b1; a_di = '0;
         @(negedge clk);
         n_chk++;
         if ({a_vo, a_do} !== {1'b1, ks_k1[i]}) begin
            n_fail++;
            $display("FAIL equiv_w32_word%0d: vld/dat=%b/%h, expected 1/%h", i, a_vo, a_do, ks_k1[i]);
         end
      end
      a_vi = 1'b0;
      b_start(K1, V1, cyc);
      n_chk++;
      if (cyc != 1152) begin
         n_fail++;
         $display("FAIL equiv_w1_warmup: %0d cycles, expected 1152", cyc);
      end
      b_ri = 1'b1;
      for (int i = 0; i < 64; i++) begin
         r = '0;
         for (int k = 0; k < 32; k++) begin
            b_vi = 1'b1; b_di = '0;
            @(negedge clk);
            r[k] = b_vo & b_do[0];
            if (!b_vo) r[k] = 1'bx;
         end
         n_chk++;
         if (r !== ks_k1[i]) begin
            n_fail++;
            $display("FAIL equiv_w1_word%0d: bits=%h, expected %h", i, r, ks_k1[i]);
         end
      end
      b_vi = 1'b0;
   endtask

   task automatic test_back_to_back();
      int cyc, consumed;
      int pat[4] = '{1, 0, 0, 1};
      logic [7:0] q[$];
      logic [7:0] held, d, e;
      logic stalled;
      logic [63:0] z;
      m_init(K2, V2);
      c_start(K2, V2, cyc);
      n_chk++;
      if (cyc != 144) begin
         n_fail++;
         $display("FAIL bp_warmup: %0d cycles, expected 144", cyc);
      end
      d = 8'h00; stalled = 1'b0; held = '0; consumed = 0;
      for (int t = 0; t < 56; t++) begin
         c_ri = (t < 48) ? pat[t % 4][0] : 1'b1;
         c_vi = t < 48; c_di = d;
         #1;
         if (stalled) begin
            n_chk++;
            if ({c_vo, c_do} !== {1'b1, held}) begin
               n_fail++;
               $display("FAIL bp_hold_t%0d: vld/dat=%b/%h, expected 1/%h", t, c_vo, c_do, held);
            end
         end
         if (c_vo && c_ri) begin
            e = q.size() > 0 ? q.pop_front() : 8'hxx;
            n_chk++;
            consumed++;
            if (c_do !== e) begin
               n_fail++;
               $display("FAIL bp_word_t%0d: dat=%h, expected %h", t, c_do, e);
            end
         end
         if (c_vi && c_ro) begin
            m_word(8, z);
            q.push_back(d ^ z[7:0]);
            d++;
         end
         stalled = c_vo && !c_ri;
         held = c_do;
         @(negedge clk);
      end
      c_vi = 1'b0;
      n_chk++;
      if (q.size() != 0 || consumed < 20) begin
         n_fail++;
         $display("FAIL bp_drain: %0d left, %0d consumed, expected 0 left and >=20", q.size(), consumed);
      end
   endtask

   task automatic test_roundtrip();
      int cyc;
      logic [31:0] ct [16];
      a_ri = 1'b1;
      a_start(K1, V2, cyc);
      for (int i = 0; i < 16; i++) begin
         a_vi = 1'b1; a_di = PT;
         @(negedge clk);
         ct[i] = a_do;
      end
      a_vi = 1'b0;
      a_start(K1, V2, cyc);
      for (int i = 0; i < 16; i++) begin
         a_vi = 1'b1; a_di = ct[i];
         @(negedge clk);
         n_chk++;
         if ({a_vo, a_do} !== {1'b1, PT}) begin
            n_fail++;
            $display("FAIL roundtrip_word%0d: vld/dat=%b/%h, expected 1/%h", i, a_vo, a_do, PT);
         end
      end
      a_vi = 1'b0;
   endtask

   task automatic test_abort();
      int cyc;
      logic [63:0] z;
      a_ri = 1'b1;
      @(negedge clk);
      a_key = K1; a_iv = V1; a_init = 1'b1;
      @(negedge clk);
      a_init = 1'b0;
      repeat (9) @(negedge clk);
      a_start(K2, V2, cyc);
      n_chk++;
      if (cyc != 36) begin
         n_fail++;
         $display("FAIL restart_len: busy for %0d cycles after re-init, expected 36", cyc);
      end
      m_init(K2, V2);
      m_word(32, z);
      a_vi = 1'b1; a_di = 32'h12345678;
      @(negedge clk);
      n_chk++;
      if ({a_vo, a_do} !== {1'b1, z[31:0] ^ 32'h12345678}) begin
         n_fail++;
         $display("FAIL restart_word: vld/dat=%b/%h, expected 1/%h", a_vo, a_do, z[31:0] ^ 32'h12345678);
      end
      a_ri = 1'b0; a_vi = 1'b1; a_di = 32'hCAFEF00D;
      @(negedge clk);
      a_vi = 1'b0; a_end = 1'b1;
      @(negedge clk);
      a_end = 1'b0; a_vi = 1'b1;
      #1;
      n_chk++;
      if ({a_vo, a_busy, a_ro} !== 3'b000) begin
         n_fail++;
         $display("FAIL end_pending: vld/busy/rdy=%b%b%b, expected 000", a_vo, a_busy, a_ro);
      end
      a_vi = 1'b0;
      @(negedge clk);
      a_init = 1'b1; a_end = 1'b1; a_key = K1; a_iv = V1;
      @(negedge clk);
      a_init = 1'b0; a_end = 1'b0;
      n_chk++;
      if (a_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL init_end_same: busy=%b, expected 1", a_busy);
      end
      repeat (40) @(negedge clk);
   endtask

   task automatic test_async_reset();
      int cyc;
      a_start(K1, V1, cyc);
      a_ri = 1'b0; a_vi = 1'b1; a_di = 32'h0BADBEEF;
      @(negedge clk);
      a_vi = 1'b0;
      #1 n_rst = 1'b0;
      #1;
      n_chk++;
      if ({a_busy, a_ro, a_vo, a_do} !== 35'd0) begin
         n_fail++;
         $display("FAIL async_reset: busy/rdy/vld/dat=%b/%b/%b/%h, expected all 0", a_busy, a_ro, a_vo, a_do);
      end
      #1 n_rst = 1'b1;
      @(negedge clk);
      a_vi = 1'b1; a_ri = 1'b1; a_di = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_chk++;
         if ({a_vo, a_ro, a_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset_ignore%0d: vld/rdy/busy=%b%b%b, expected 000", i, a_vo, a_ro, a_busy);
         end
      end
      a_vi = 1'b0;
      a_start(K1, V1, cyc);
      a_vi = 1'b1; a_di = '0;
      @(negedge clk);
      a_vi = 1'b0;
      n_chk++;
      if ({a_vo, a_do} !== {1'b1, ks_k1[0]}) begin
         n_fail++;
         $display("FAIL post_reset_word: vld/dat=%b/%h, expected 1/%h", a_vo, a_do, ks_k1[0]);
      end
   endtask

   initial begin
      test_reset();
      test_warmup();
      test_equiv();
      test_back_to_back();
      test_roundtrip();
      test_abort();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
